// File: rtl/jt12_opmod_hd.sv
// jt12_opmod_hd: operator front end for phase modulation.
//   Holds per-channel operator history (prev1, prevprev1, prev2) in three
//   rings, selects X/Y operands, sums them, applies the feedback/normal
//   shift with optional saturation and delays the result to the phase-add
//   stage.
// Ports:
//   clk, rst_n (sync, active low), clk_en (advance enable)
//   op_in            current operator result (signed, W bits)
//   s1..s4_enters    slot flags
//   xuse_*, yuse_*   operand selects
//   fb               feedback level used on the S1 slot
//   clr_ch           write zeros into this slot's history
//   pm_out, pm_s1    phase modulation and its S1 flag, phase-add aligned
module jt12_opmod_hd #(
    parameter int W      = 28,
    parameter int PMW    = 20,
    parameter int NUM_CH = 6,
    parameter int PM_DLY = 6,
    parameter bit SAT    = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    input  logic [W-1:0]   op_in,
    input  logic           s1_enters,
    input  logic           s2_enters,
    input  logic           s3_enters,
    input  logic           s4_enters,
    input  logic           xuse_prevprev1,
    input  logic           xuse_prev2,
    input  logic           xuse_internal,
    input  logic           yuse_prev1,
    input  logic           yuse_prev2,
    input  logic           yuse_internal,
    input  logic [2:0]     fb,
    input  logic           clr_ch,
    output logic [PMW-1:0] pm_out,
    output logic           pm_s1
);
    localparam int B   = W + 1 - PMW;
    localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam bit OPN = (NUM_CH == 3);

    // Signed PMW limits expressed at the W+1 sum width
    localparam logic signed [W:0] MAXV = {{(B+1){1'b0}}, {(PMW-1){1'b1}}};
    localparam logic signed [W:0] MINV = {{(B+1){1'b1}}, {(PMW-1){1'b0}}};

    // s4_enters carries no routing in either history layout
    logic unused_ok;
    assign unused_ok = s4_enters;

    // History rings and pointer
    logic [W-1:0]  p1_q  [NUM_CH];
    logic [W-1:0]  pp1_q [NUM_CH];
    logic [W-1:0]  p2_q  [NUM_CH];
    logic [PW-1:0] ptr_q, ptr_d;

    logic [W-1:0] p1_rd, pp1_rd, p2_rd;
    logic [W-1:0] p1_wr, pp1_wr, p2_wr;
    logic [W-1:0] x_op, y_op;
    logic signed [W:0] sum_d;

    // Stage II and output pipeline
    logic signed [W:0] sum_q;
    logic              s1_q;
    logic [2:0]        fb_q;
    logic signed [W:0] shifted;
    logic [PMW-1:0]    pm_d;
    logic [PMW-1:0]    pm_q  [PM_DLY+1];
    logic              s1p_q [PM_DLY+1];

    assign ptr_d  = (ptr_q == PW'(NUM_CH-1)) ? '0 : ptr_q + 1'b1;

    // Read-before-write: the entry at the pointer was written NUM_CH enables ago
    assign p1_rd  = p1_q[ptr_q];
    assign pp1_rd = pp1_q[ptr_q];
    assign p2_rd  = p2_q[ptr_q];

    always_comb begin
        if (OPN) begin
            p1_wr  = s1_enters ? op_in : p1_rd;
            pp1_wr = s3_enters ? op_in : pp1_rd;
            p2_wr  = s2_enters ? op_in : p2_rd;
        end else begin
            p1_wr  = s2_enters ? op_in : p1_rd;
            pp1_wr = s2_enters ? p1_rd : pp1_rd;
            p2_wr  = s1_enters ? op_in : p2_rd;
        end
        if (clr_ch) begin
            p1_wr  = '0;
            pp1_wr = '0;
            p2_wr  = '0;
        end
    end

    always_comb begin
        x_op = xuse_prevprev1 ? pp1_rd :
               xuse_prev2     ? p2_rd  :
               xuse_internal  ? op_in  : '0;
        y_op = yuse_prev1     ? p1_rd  :
               yuse_prev2     ? p2_rd  :
               yuse_internal  ? op_in  : '0;
        sum_d = $signed({x_op[W-1], x_op}) + $signed({y_op[W-1], y_op});
    end

    // fb travels with its sum so the shift uses the level of the same slot
    always_comb begin
        shifted = '0;
        if (!s1_q)
            shifted = sum_q >>> (B - 4);
        else if (fb_q != 3'd0)
            shifted = sum_q >>> (B + 5 - int'(fb_q));

        pm_d = shifted[PMW-1:0];
        if (SAT) begin
            if (shifted > MAXV)      pm_d = MAXV[PMW-1:0];
            else if (shifted < MINV) pm_d = MINV[PMW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                p1_q[i]  <= '0;
                pp1_q[i] <= '0;
                p2_q[i]  <= '0;
            end
            sum_q <= '0;
            s1_q  <= 1'b0;
            fb_q  <= '0;
            for (int i = 0; i <= PM_DLY; i++) begin
                pm_q[i]  <= '0;
                s1p_q[i] <= 1'b0;
            end
        end else if (clk_en) begin
            ptr_q        <= ptr_d;
            p1_q[ptr_q]  <= p1_wr;
            pp1_q[ptr_q] <= pp1_wr;
            p2_q[ptr_q]  <= p2_wr;
            sum_q        <= sum_d;
            s1_q         <= s1_enters;
            fb_q         <= fb;
            pm_q[0]      <= pm_d;
            s1p_q[0]     <= s1_q;
            for (int i = 1; i <= PM_DLY; i++) begin
                pm_q[i]  <= pm_q[i-1];
                s1p_q[i] <= s1p_q[i-1];
            end
        end
    end

    assign pm_out = pm_q[PM_DLY];
    assign pm_s1  = s1p_q[PM_DLY];
endmodule

// File: tb/tb_jt12_opmod_hd.sv
// Directed bench for jt12_opmod_hd: three instances share one stimulus bus
// (default SAT=0/6ch, SAT=1/6ch, SAT=0/3ch).
module tb_jt12_opmod_hd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clk_en, clr_ch;
    logic [27:0] op_in;
    logic        s1e, s2e, s3e, s4e;
    logic        xpp1, xp2, xin, yp1, yp2, yin;
    logic [2:0]  fb;
    logic [19:0] pm0, pm1, pm2;
    logic        ps0, ps1, ps2;

    int checks = 0;
    int errors = 0;
    int e = 0;
    logic [19:0] r0 [0:511];
    logic [19:0] r2 [0:511];

    jt12_opmod_hd #(.SAT(1'b0), .NUM_CH(6)) u0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .op_in(op_in),
        .s1_enters(s1e), .s2_enters(s2e), .s3_enters(s3e), .s4_enters(s4e),
        .xuse_prevprev1(xpp1), .xuse_prev2(xp2), .xuse_internal(xin),
        .yuse_prev1(yp1), .yuse_prev2(yp2), .yuse_internal(yin),
        .fb(fb), .clr_ch(clr_ch), .pm_out(pm0), .pm_s1(ps0));
    jt12_opmod_hd #(.SAT(1'b1), .NUM_CH(6)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .op_in(op_in),
        .s1_enters(s1e), .s2_enters(s2e), .s3_enters(s3e), .s4_enters(s4e),
        .xuse_prevprev1(xpp1), .xuse_prev2(xp2), .xuse_internal(xin),
        .yuse_prev1(yp1), .yuse_prev2(yp2), .yuse_internal(yin),
        .fb(fb), .clr_ch(clr_ch), .pm_out(pm1), .pm_s1(ps1));
    jt12_opmod_hd #(.SAT(1'b0), .NUM_CH(3)) u2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .op_in(op_in),
        .s1_enters(s1e), .s2_enters(s2e), .s3_enters(s3e), .s4_enters(s4e),
        .xuse_prevprev1(xpp1), .xuse_prev2(xp2), .xuse_internal(xin),
        .yuse_prev1(yp1), .yuse_prev2(yp2), .yuse_internal(yin),
        .fb(fb), .clr_ch(clr_ch), .pm_out(pm2), .pm_s1(ps2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // One clock; outputs recorded at the following negedge, indexed by enable count
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (clk_en && rst_n && e < 511) begin
            e++;
            r0[e] = pm0;
            r2[e] = pm2;
        end
    endtask

    task automatic run(input int n);
        clk_en = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic quiet();
        s1e = 0; s2e = 0; s3e = 0; s4e = 0;
        xpp1 = 0; xp2 = 0; xin = 0; yp1 = 0; yp2 = 0; yin = 0;
        clr_ch = 0; op_in = '0;
    endtask

    int base, a, c, d, s;
    int fbv [4] = '{5, 7, 0, 1};
    logic [19:0] fbe [4] = '{20'h01000, 20'h04000, 20'h00000, 20'h00100};

    initial begin
        rst_n = 1; clk_en = 1; fb = 3'd3; quiet();
        @(negedge clk);

        // Junk traffic, then a one-clock reset with clk_en low
        op_in = 28'h5A5A5A5; s1e = 1; s2e = 1; s3e = 1; xin = 1; yin = 1;
        run(10);
        rst_n = 0; clk_en = 0;
        cyc();
        chk("rst_pm0", pm0, 0);
        chk("rst_pm1", pm1, 0);
        chk("rst_pm2", pm2, 0);
        chk("rst_s1", {ps0, ps1, ps2}, 0);
        rst_n = 1;

        // History reads zero after reset
        quiet(); op_in = 28'h5A5A5A5; xpp1 = 1; yp1 = 1; xp2 = 0;
        base = e;
        run(14);
        for (int i = 1; i <= 6; i++) begin
            chk("hist_zero6", r0[base+i+7], 0);
            chk("hist_zero3", r2[base+i+7], 0);
        end

        // Non-S1 path with exact latency
        quiet(); fb = 3'd0; op_in = 28'h0100000; xin = 1;
        base = e;
        run(8);
        chk("lat_early", r0[base+7], 0);
        chk("nons1", r0[base+8], 20'h08000);
        chk("nons1_s1", ps0, 0);

        // Feedback on S1, x=y=internal
        for (int k = 0; k < 4; k++) begin
            quiet(); s1e = 1; xin = 1; yin = 1; op_in = 28'h0100000; fb = 3'(fbv[k]);
            run(8);
            chk($sformatf("fb%0d", fbv[k]), pm0, fbe[k]);
            chk("fb_s1", ps0, 1);
        end

        // Saturation vs wrap
        quiet(); s1e = 1; xin = 1; yin = 1; fb = 3'd7; op_in = 28'h7000000;
        run(8);
        chk("wrap_pos", pm0, 20'hC0000);
        chk("sat_pos", pm1, 20'h7FFFF);
        op_in = 28'h9000000;
        run(8);
        chk("sat_neg", pm1, 20'h80000);
        chk("wrap_neg", pm0, 20'h40000);

        // History move prev1 -> prevprev1 (6-channel routing)
        rst_n = 0; cyc(); rst_n = 1;
        quiet(); fb = 3'd0;
        op_in = 28'h123; s2e = 1; cyc(); a = e;
        quiet(); run(5);
        yp1 = 1; s2e = 1; cyc();                  // edge a+6
        quiet(); run(5);
        xpp1 = 1; yp1 = 1; cyc();                 // edge a+12
        quiet(); run(8);
        chk("hist_prev1", r0[a+13], 20'h00009);
        chk("hist_pp1", r0[a+19], 20'h00009);

        // Clear overrides enters flag
        op_in = 28'h123; s2e = 1; clr_ch = 1; cyc(); c = e;
        quiet(); run(5);
        yp1 = 1; cyc();
        quiet(); run(8);
        chk("clr", r0[c+13], 0);

        // 3-channel routing: s3_enters writes prevprev1
        op_in = 28'h240; s3e = 1; cyc(); d = e;
        quiet(); run(2);
        xpp1 = 1; cyc();
        quiet(); run(8);
        chk("opn_pp1", r2[d+10], 20'h00012);

        // Stall mid-stream
        quiet(); xin = 1;
        s = e + 1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 9) begin
                clk_en = 0;
                repeat (5) begin
                    cyc();
                    chk("stall_hold", pm0, 20'h00020);
                end
                clk_en = 1;
            end
            op_in = 28'(i << 10);
            cyc();
        end
        quiet(); run(8);
        for (int i = 1; i <= 10; i++)
            chk($sformatf("seq%0d", i), r0[s+i-1+7], 20'(i << 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt12_opmod_hd.md
Name: jt12_opmod_hd

Overview:
Parametrised successor of the high-precision operator front end. It stores per-channel operator history (prev1, prevprev1, prev2) and builds the phase-modulation word from the selected X/Y operands. It applies the feedback shift and an optional saturation, then delays the result to the phase-add stage. Width, channel count, modulation width and pipeline depth are generic. History is cleared by reset and can be cleared per channel.

Parameters:
W, 28, operator result width (signed)
PMW, 20, phase-modulation output width (signed); W+1-PMW must be >= 7
NUM_CH, 6, channels; 3 selects OPN (3-channel) history routing, any other value 1..8 uses 6-channel routing
PM_DLY, 6, extra register stages after stage II (0 allowed)
SAT, 0, 1 = clamp shifted result to signed PMW range; 0 = wrap (discard upper bits)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clk_en  in  1  advance enable; all state holds when low
op_in  in  W  current operator result (internal)
s1_enters, s2_enters, s3_enters, s4_enters  in  1 each  slot flags
xuse_prevprev1, xuse_prev2, xuse_internal  in  1 each  X select
yuse_prev1, yuse_prev2, yuse_internal  in  1 each  Y select
fb  in  3  feedback level for the S1 slot
clr_ch  in  1  zero this slot's history writes
pm_out  out  PMW  phase modulation, aligned to the phase-add stage
pm_s1  out  1  s1 flag aligned with pm_out

Behaviour:
- Reset: the clock is clk and the reset is rst_n, which is synchronous and active-low, with one clock domain. Reset is sampled on the clk edge regardless of clk_en. It zeroes all history entries, the ring pointer, every pipeline stage, pm_out and pm_s1.
- History: three rings of NUM_CH x W entries, driven by one pointer that runs 0..NUM_CH-1 and wraps to 0. The pointer advances once per clk_en edge. Each ring reads the entry written NUM_CH enables earlier (read-before-write at the pointer).
- Write data for NUM_CH==3:
  - prev1 = s1_enters ? op_in : prev1
  - prevprev1 = s3_enters ? op_in : prevprev1
  - prev2 = s2_enters ? op_in : prev2
- Write data otherwise:
  - prev1 = s2_enters ? op_in : prev1
  - prevprev1 = s2_enters ? prev1 : prevprev1
  - prev2 = s1_enters ? op_in : prev2
- clr_ch high: all three rings write 0 at the pointer. It overrides any enters flag.
- X select priority: prevprev1 > prev2 > internal > 0. Y select priority: prev1 > prev2 > internal > 0.
- Operand sum: sum = sext(X) + sext(Y), W+1 bits. It cannot overflow.
- Stage II: sum and s1_enters are registered on clk_en.
- Shift: arithmetic right shift of the registered sum, keeping the low PMW bits. Let B = W+1-PMW.
  - Not S1: shift B-4.
  - S1 with fb=0: result 0.
  - S1 with fb=k (1..7): shift B+5-k.
- Saturation: SAT=1 clamps any shifted value outside [-2^(PMW-1), 2^(PMW-1)-1] to the limit. SAT=0 truncates.
- Output pipeline: the shifted value and the s1 flag pass through PM_DLY registers.
- Latency: operands presented at clk_en edge n appear on pm_out after edge n+1+PM_DLY, counted in clk_en edges.
- clk_en low: no pointer advance, no writes, outputs stable.
- Reset mid-operation: everything is zero on the next edge. The pointer restarts at 0, and the first NUM_CH reads return 0.

Test Plan:
- Reset: drive junk, then rst_n=0 for 1 clk with clk_en=0. Expect pm_out=0 and pm_s1=0 at once, and all history reads 0 for the next 6 enables.
- Non-S1 path (default params): op_in=0x0100000, xuse_internal=1, no Y. Expect pm_out=0x08000 after 7 enables, pm_s1=0.
- Feedback, S1 with x=y=internal, op_in=0x0100000:
  - fb=5 gives pm_out=0x01000.
  - fb=7 gives 0x04000.
  - fb=0 gives 0.
  - fb=1 gives 0x00100.
- Saturation: S1, fb=7, x=y=internal, op_in=0x7000000.
  - SAT=1: pm_out=0x7FFFF.
  - SAT=0: pm_out=0xC0000.
  - Negative mirror, op_in=0x9000000 with SAT=1: pm_out=0x80000.
- History and clear:
  - Write op_in=0x123 with s2_enters. Six enables later, yuse_prev1 yields Y=0x123, and the next s2_enters moves it into prevprev1.
  - Repeat with clr_ch=1 during the write: the read returns 0.
- NUM_CH=3 and stall:
  - With NUM_CH=3, s3_enters writes prevprev1, readable 3 enables later.
  - Insert 5 cycles of clk_en=0 mid-stream: outputs freeze and the result sequence is unchanged.
